// File: rtl/eth_tpg_pkg.sv
// Shared types and constants for the Ethernet TX test-pattern generator.
package eth_tpg_pkg;

  typedef enum logic [1:0] {
    INCR  = 2'd0,
    FIXED = 2'd1,
    PRBS7 = 2'd2,
    WALK1 = 2'd3
  } tpg_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tpg_state_e;

  // Feedback taps of x^7 + x^6 + 1 (bit indices of the 7-bit shift register)
  localparam int PRBS7_TAP_HI = 6;
  localparam int PRBS7_TAP_LO = 5;

  localparam logic [7:0] INCR_FIRST  = 8'h01;
  localparam logic [7:0] WALK1_FIRST = 8'h01;

endpackage

// File: rtl/eth_tpg_lfsr.sv
// PRBS7 generator (x^7+x^6+1). byte_o holds the next eight serial output
// bits (first bit in bit 0); adv_en moves the register on by those 8 steps.
module eth_tpg_lfsr #(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv_en,
  output logic [7:0] byte_o
);
  import eth_tpg_pkg::*;

  logic [6:0] state_q, state_d;
  logic [6:0] walk_s;
  logic       fb;

  // Unroll eight serial steps to form the byte and the advanced state
  always_comb begin
    walk_s = state_q;
    fb     = 1'b0;
    byte_o = '0;
    for (int i = 0; i < 8; i++) begin
      fb        = walk_s[PRBS7_TAP_HI] ^ walk_s[PRBS7_TAP_LO];
      byte_o[i] = fb;
      walk_s    = {walk_s[5:0], fb};
    end
    state_d = adv_en ? walk_s : state_q;
  end

  // Register holds its value across packets and runs; only reset reseeds it
  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/eth_tx_tpg_gen.sv
// Ethernet TX test-pattern generator: runs of N packets of programmable
// length/pattern with valid/ready backpressure and an inter-packet gap.
module eth_tx_tpg_gen #(
  parameter int         DATA_W    = 8,
  parameter int         LEN_W     = 11,
  parameter int         CNT_W     = 8,
  parameter logic [6:0] PRBS_SEED = 7'h7F
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Tpg_Start,
  input  logic              Tpg_Abort,
  input  logic [1:0]        Tpg_Mode,
  input  logic [DATA_W-1:0] Tpg_Fixed,
  input  logic [LEN_W-1:0]  Tpg_Pkt_Len,
  input  logic [CNT_W-1:0]  Tpg_Pkt_Num,
  input  logic [CNT_W-1:0]  Tpg_Ipg,
  output logic [DATA_W-1:0] Eth_Byte,
  output logic              Eth_Byte_Valid,
  input  logic              Eth_Byte_Rdy,
  output logic              Eth_Byte_Last,
  output logic              Eth_Pkt_Rdy,
  output logic              Tpg_Busy,
  output logic [15:0]       Tpg_Pkts_Sent
);
  import eth_tpg_pkg::*;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SEND = SEND;
  localparam logic [1:0] ST_GAP  = GAP;

  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              sync_dly_q, sync_dly_d, start_pulse_q, start_pulse_d;
  logic [1:0]        state_q, state_d;
  tpg_mode_e         mode_q, mode_d;
  logic [DATA_W-1:0] fixed_q, fixed_d;
  logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
  logic [CNT_W-1:0]  num_q, num_d, ipg_q, ipg_d, done_q, done_d, gap_q, gap_d;
  logic [15:0]       sent_q, sent_d;
  logic              pkt_rdy_q, pkt_rdy_d;

  logic              valid, is_last, beat, run_done, lfsr_adv;
  logic [7:0]        prbs_byte, pat8;
  logic [DATA_W-1:0] byte_full;

  // Two-flop synchroniser on the async start level plus a registered rising-edge pulse
  always_comb begin
    sync1_d       = Tpg_Start;
    sync2_d       = sync1_q;
    sync_dly_d    = sync2_q;
    start_pulse_d = sync2_q & ~sync_dly_q;
  end

  assign valid    = (state_q == ST_SEND);
  assign is_last  = valid && (idx_q == len_q - LEN_W'(1));
  assign beat     = valid && Eth_Byte_Rdy && !Tpg_Abort;
  assign run_done = (num_q != '0) && ((done_q + CNT_W'(1)) == num_q);
  assign lfsr_adv = beat && (mode_q == PRBS7);

  // Run control: latch config on start, step byte/packet/gap counters, abort wins
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    fixed_d   = fixed_q;
    len_d     = len_q;
    num_d     = num_q;
    ipg_d     = ipg_q;
    idx_d     = idx_q;
    done_d    = done_q;
    gap_d     = gap_q;
    sent_d    = sent_q;
    pkt_rdy_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_pulse_q && !Tpg_Abort && (Tpg_Pkt_Len != '0)) begin
          mode_d  = tpg_mode_e'(Tpg_Mode);
          fixed_d = Tpg_Fixed;
          len_d   = Tpg_Pkt_Len;
          num_d   = Tpg_Pkt_Num;
          ipg_d   = Tpg_Ipg;
          idx_d   = '0;
          done_d  = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (beat) begin
          if (is_last) begin
            pkt_rdy_d = 1'b1;
            sent_d    = sent_q + 16'd1;
            done_d    = done_q + CNT_W'(1);
            idx_d     = '0;
            if (run_done) begin
              state_d = ST_IDLE;
            end else if (ipg_q != '0) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == ipg_q - CNT_W'(1)) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (Tpg_Abort) state_d = ST_IDLE;
  end

  // All state registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync_dly_q    <= 1'b0;
      start_pulse_q <= 1'b0;
      state_q       <= ST_IDLE;
      mode_q        <= INCR;
      fixed_q       <= '0;
      len_q         <= '0;
      num_q         <= '0;
      ipg_q         <= '0;
      idx_q         <= '0;
      done_q        <= '0;
      gap_q         <= '0;
      sent_q        <= '0;
      pkt_rdy_q     <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      sync_dly_q    <= sync_dly_d;
      start_pulse_q <= start_pulse_d;
      state_q       <= state_d;
      mode_q        <= mode_d;
      fixed_q       <= fixed_d;
      len_q         <= len_d;
      num_q         <= num_d;
      ipg_q         <= ipg_d;
      idx_q         <= idx_d;
      done_q        <= done_d;
      gap_q         <= gap_d;
      sent_q        <= sent_d;
      pkt_rdy_q     <= pkt_rdy_d;
    end
  end

  eth_tpg_lfsr #(
    .SEED (PRBS_SEED)
  ) u_lfsr (
    .clk    (Clk),
    .rst    (Rst),
    .adv_en (lfsr_adv),
    .byte_o (prbs_byte)
  );

  // Pattern byte depends only on the byte index and LFSR, so it holds while stalled
  always_comb begin
    pat8 = '0;
    case (mode_q)
      INCR:    pat8 = idx_q[7:0] + INCR_FIRST;
      PRBS7:   pat8 = prbs_byte;
      WALK1:   pat8 = WALK1_FIRST << idx_q[2:0];
      default: pat8 = '0;
    endcase
    if (mode_q == FIXED) byte_full = fixed_q;
    else                 byte_full = {(DATA_W/8){pat8}};
  end

  assign Eth_Byte       = valid ? byte_full : '0;
  assign Eth_Byte_Valid = valid;
  assign Eth_Byte_Last  = is_last;
  assign Eth_Pkt_Rdy    = pkt_rdy_q;
  assign Tpg_Busy       = (state_q != ST_IDLE);
  assign Tpg_Pkts_Sent  = sent_q;

endmodule
